// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: control from the pipeline, byte-wide RAM port,
// and the pc/inst pair handed to the IF/ID register.
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  logic              stall_in;
  logic              branch_in;
  logic [ADDR_W-1:0] branch_target_in;
  logic              mem_busy_in;
  logic [7:0]        mem_din_in;
  logic [ADDR_W-1:0] mem_a_out;
  logic              mem_rd_out;
  logic [ADDR_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              inst_valid_out;

  modport master (
    input  stall_in, branch_in, branch_target_in, mem_busy_in, mem_din_in,
    output mem_a_out, mem_rd_out, pc_out, inst_out, inst_valid_out
  );

  modport slave (
    output stall_in, branch_in, branch_target_in, mem_busy_in, mem_din_in,
    input  mem_a_out, mem_rd_out, pc_out, inst_out, inst_valid_out
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: reads four little-endian bytes per instruction from a
// shared byte RAM port, holds the result under stall, restarts on redirect.
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  if_fetch_if.master   bus
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned RECV_W  = 2;
  localparam int unsigned N_BYTES = 4;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        fetch_pc;
  logic [CNT_W-1:0]         issue_cnt;
  logic [RECV_W-1:0]        recv_cnt;
  logic                     issued_q;
  logic [2:0][7:0]          byte_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [INST_W-1:0]        inst_q;
  logic                     valid_q;
  logic                     rd_c;

  // Issue a byte read only while fetching, port free and no redirect pending.
  assign rd_c = (state == FETCH) && (issue_cnt < CNT_W'(N_BYTES))
                && !bus.mem_busy_in && !bus.branch_in;

  assign bus.mem_rd_out     = rd_c;
  assign bus.mem_a_out      = fetch_pc + ADDR_W'(issue_cnt);
  assign bus.pc_out         = pc_q;
  assign bus.inst_out       = inst_q;
  assign bus.inst_valid_out = valid_q;

  // Fetch sequencing; a redirect overrides everything including completion.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      issued_q  <= 1'b0;
      byte_q    <= '0;
      pc_q      <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else if (bus.branch_in) begin
      state     <= FETCH;
      fetch_pc  <= {bus.branch_target_in[ADDR_W-1:2], 2'b00};
      issue_cnt <= '0;
      recv_cnt  <= '0;
      issued_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (rd_c) issue_cnt <= issue_cnt + CNT_W'(1);
          issued_q <= rd_c;
          if (issued_q) begin
            // Last byte goes straight into the word rather than the buffer.
            if (recv_cnt == RECV_W'(N_BYTES - 1)) begin
              inst_q  <= INST_W'({bus.mem_din_in, byte_q[2], byte_q[1], byte_q[0]});
              pc_q    <= fetch_pc;
              valid_q <= 1'b1;
              state   <= HOLD;
            end else begin
              byte_q[recv_cnt] <= bus.mem_din_in;
              recv_cnt         <= recv_cnt + RECV_W'(1);
            end
          end
        end
        HOLD: begin
          if (!bus.stall_in) begin
            valid_q   <= 1'b0;
            fetch_pc  <= fetch_pc + ADDR_W'(N_BYTES);
            issue_cnt <= '0;
            recv_cnt  <= '0;
            issued_q  <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a transaction-level fetch model
// predicts RAM reads and presented pc/inst pairs; a monitor checks them.
module tb_if_fetch;

  localparam int unsigned N_CYC = 3000;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  logic [7:0] ram [1024];

  // Byte RAM: data one cycle after the address; garbage when not read.
  always @(posedge clk_in) begin
    if (bus.mem_rd_out) bus.mem_din_in <= ram[bus.mem_a_out[9:0]];
    else                bus.mem_din_in <= 8'($urandom);
  end

  int n_vec = 0;
  int n_err = 0;
  int n_pres = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {ram[a3[9:0]], ram[a2[9:0]], ram[a1[9:0]], ram[a[9:0]]};
  endfunction

  typedef struct {
    bit          valid;
    bit          rd;
    logic [31:0] addr;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pres_t;

  cyc_t  cq[$];
  pres_t pq[$];

  // Model: instruction at m_pc, bytes requested so far, bytes in hand.
  logic [31:0] m_pc;
  int          m_req;
  int          m_have;
  bit          m_inflight;
  bit          m_present;

  task automatic model_reset();
    m_pc = 32'h0; m_req = 0; m_have = 0; m_inflight = 0; m_present = 0;
    cq.delete();
    pq.delete();
  endtask

  task automatic model_step(input bit stall, input bit br, input logic [31:0] tgt, input bit busy);
    cyc_t e;
    e.valid = m_present;
    e.rd    = !m_present && (m_req < 4) && !busy && !br;
    e.addr  = m_pc + 32'(m_req);
    cq.push_back(e);
    if (br) begin
      m_pc = tgt & ~32'd3; m_req = 0; m_have = 0; m_inflight = 0; m_present = 0;
    end else if (m_present) begin
      if (!stall) begin
        m_pc = m_pc + 32'd4; m_req = 0; m_have = 0; m_inflight = 0; m_present = 0;
      end
    end else begin
      if (m_inflight) m_have++;
      if (m_have == 4) begin
        m_present = 1;
        pq.push_back('{pc: m_pc, inst: word_at(m_pc)});
      end
      m_inflight = e.rd;
      if (e.rd) m_req++;
    end
  endtask

  // Monitor: per-cycle read/valid expectations, plus pc/inst on each presentation.
  initial begin
    cyc_t  e;
    pres_t cur;
    bit    prev_v;
    prev_v = 0;
    cur    = '{pc: 32'h0, inst: 32'h0};
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        prev_v = 0;
        continue;
      end
      if (cq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sched: no expectation queued at %0t", $time);
        continue;
      end
      e = cq.pop_front();
      chk("valid", 32'(bus.inst_valid_out), 32'(e.valid));
      chk("mem_rd", 32'(bus.mem_rd_out), 32'(e.rd));
      if (e.rd && bus.mem_rd_out) chk("mem_a", bus.mem_a_out, e.addr);
      if (bus.inst_valid_out && !prev_v) begin
        if (pq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL present: unexpected pc %h inst %h", bus.pc_out, bus.inst_out);
        end else begin
          cur = pq.pop_front();
          chk("pc", bus.pc_out, cur.pc);
          chk("inst", bus.inst_out, cur.inst);
          if (n_pres == 0) chk("first_inst", bus.inst_out, 32'h00A00513);
          n_pres++;
        end
      end else if (bus.inst_valid_out) begin
        chk("hold_pc", bus.pc_out, cur.pc);
        chk("hold_inst", bus.inst_out, cur.inst);
      end
      prev_v = bus.inst_valid_out;
    end
  end

  // Driver: directed opening matching the fetch scenarios, then random traffic.
  initial begin
    bit          stall, br, busy, did_rst;
    logic [31:0] tgt;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
    bus.stall_in = 0; bus.branch_in = 0; bus.branch_target_in = '0; bus.mem_busy_in = 0;
    did_rst = 0;
    model_reset();
    #3;
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_inst", bus.inst_out, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid_out), 32'h0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      if (cyc >= 300 && !did_rst && !m_present && m_req == 2) begin
        did_rst = 1;
        rst_in = 0;
        bus.stall_in = 0; bus.branch_in = 0; bus.mem_busy_in = 0;
        #1;
        chk("async_rst_pc", bus.pc_out, 32'h0);
        chk("async_rst_inst", bus.inst_out, 32'h0);
        chk("async_rst_valid", 32'(bus.inst_valid_out), 32'h0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1;
        model_reset();
      end
      stall = 0; br = 0; busy = 0; tgt = 32'h0;
      if (cyc < 70) begin
        if (cyc >= 5 && cyc <= 9) stall = 1;
        if (cyc == 19 || cyc == 20) busy = 1;
        if (cyc == 27) begin br = 1; tgt = 32'h103; end
        if (cyc == 40) begin br = 1; tgt = 32'hFFFF_FFF6; end
      end else begin
        stall = ($urandom % 5) < 2;
        busy  = ($urandom % 4) == 0;
        br    = ($urandom % 20) == 0;
        // Aim redirects at completion and acceptance edges.
        if ((m_present || (!m_present && m_inflight && m_have == 3)) && ($urandom % 4) == 0) br = 1;
        tgt = $urandom;
        if (($urandom % 8) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom % 16);
      end
      bus.stall_in = stall; bus.branch_in = br; bus.branch_target_in = tgt; bus.mem_busy_in = busy;
      model_step(stall, br, tgt, busy);
      @(posedge clk_in); #1;
    end
    chk("sched_drained", 32'(cq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that produces the pc/inst pair consumed by the IF/ID pipeline register. It reads one 32-bit instruction as four sequential bytes from the byte-wide unified RAM port and assembles them little-endian. It presents the pc/inst pair with a valid flag, holds it while the downstream pipeline stalls, and restarts at a new address on a branch redirect. It yields the RAM port whenever the memory arbiter reports the port busy.

Parameters:
ADDR_W, 32, address width of pc and RAM address
INST_W, 32, instruction width; fixed at 4 bytes
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk_in  input  1  clock; all state updates on the rising edge
rst_in  input  1  asynchronous, active-low reset
stall_in  input  1  downstream cannot accept; hold the presented instruction
branch_in  input  1  single-cycle redirect request from EX
branch_target_in  input  ADDR_W  redirect address; bits [1:0] ignored and treated as 0
mem_busy_in  input  1  RAM port owned by another requester this cycle
mem_din_in  input  8  RAM read byte; valid the cycle after the address is issued
mem_a_out  output  ADDR_W  RAM byte address, combinational: fetch_pc + issue_cnt
mem_rd_out  output  1  RAM read strobe, combinational
pc_out  output  ADDR_W  pc of the presented instruction, to IF/ID pc_in
inst_out  output  INST_W  assembled instruction, to IF/ID inst_in
inst_valid_out  output  1  pc_out/inst_out hold a valid instruction

Behaviour:
- Reset while rst_in=0, at any time including mid-fetch: pc_out=0, inst_out=0, inst_valid_out=0, state=FETCH, fetch_pc=RESET_PC, issue_cnt=0, recv_cnt=0, issued_q=0, byte buffer=0.
- State FETCH:
  - mem_rd_out = (issue_cnt<4) & !mem_busy_in & !branch_in.
  - On each edge with mem_rd_out=1: issue_cnt++ and issued_q<=1; otherwise issued_q<=0.
  - On each edge with issued_q=1: byte[recv_cnt] <= mem_din_in, recv_cnt++.
  - When the edge captures byte 3, at that edge: inst_out <= {mem_din_in, byte2, byte1, byte0}, pc_out <= fetch_pc, inst_valid_out <= 1, state <= HOLD.
- State HOLD:
  - mem_rd_out=0.
  - Outputs are held stable while stall_in=1.
  - At the first edge with stall_in=0: inst_valid_out <= 0, fetch_pc <= fetch_pc+4 (wraps modulo 2^ADDR_W), counters <= 0, state <= FETCH.
- Latency and throughput:
  - Unstalled, no busy: addresses issue in cycles 0-3, bytes return in cycles 1-4, inst_valid_out is high in cycle 5.
  - One instruction every 6 cycles.
- mem_busy_in:
  - Suppresses issue only. A byte already issued the previous cycle is still captured in the busy cycle.
  - Issuing resumes at the same issue_cnt once busy drops. No byte is re-read.
- branch_in (highest priority, any state):
  - At that edge: fetch_pc <= {branch_target_in[ADDR_W-1:2], 2'b00}, issue_cnt/recv_cnt/issued_q <= 0, inst_valid_out <= 0, state <= FETCH.
  - The in-flight byte returning in the following cycle is discarded.
  - If branch_in coincides with byte-3 capture or with HOLD acceptance, the branch wins and the completing or held instruction is dropped.
  - pc_out/inst_out keep their old values but are invalid.
- The unit never writes memory and never asserts mem_rd_out in HOLD.
- stall_in is ignored in FETCH.

Test Plan:
- Reset, RAM[0..3]=13,05,A0,00, no stall/busy -> mem_a_out 0,1,2,3 with mem_rd_out=1 in cycles 0-3; inst_valid_out=1 in cycle 5 with inst_out=32'h00A00513, pc_out=0; next fetch issues address 4 in cycle 6.
- stall_in=1 for cycles 5-9 -> inst_out/pc_out/inst_valid_out stable through cycle 9, no mem_rd_out; address 4 issued in cycle 11.
- mem_busy_in=1 in cycles 2-3 of a fetch at pc=8 -> byte at address 9 still captured in cycle 2; addresses 10 and 11 issued in cycles 4 and 5; valid in cycle 7 with correct word.
- branch_in=1 with target 32'h103 in cycle 2 of a fetch -> mem_rd_out=0 in cycle 2; byte returned in cycle 3 is ignored; addresses 0x100-0x103 issued in cycles 3-6; pc_out=0x100 when inst_valid_out next rises (cycle 8).
- branch_in coincident with HOLD acceptance, and separately coincident with byte-3 capture -> inst_valid_out low next cycle; fetch restarts at target; the instruction at the dropped pc never reappears.
- rst_in pulled low mid-fetch at cycle 2 and released -> all outputs zero immediately (asynchronously); fetch restarts at RESET_PC from byte 0.
